dcache_controller: RTL

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and a slow line-wide data memory. It serves CPU loads and stores on a hit with zero added latency. On a miss it raises `cpu_stall_o`, which drives the `MemStall_i` freeze input of every pipeline register, and runs a writeback/refill handshake with memory. It releases the stall once the line is resident.

---
 rtl/dcache_controller_if.sv | 34 +++
 rtl/dcache_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus bundle for the data cache controller.
// The controller uses the slave modport; the CPU/memory side uses master.
interface dcache_controller_if;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    output cpu_addr_i, cpu_data_i,
    output cpu_MemRead_i, cpu_MemWrite_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o,
    input  mem_enable_o, mem_write_o
  );

  modport slave (
    input  cpu_addr_i, cpu_data_i,
    input  cpu_MemRead_i, cpu_MemWrite_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o,
    output mem_enable_o, mem_write_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate D-cache, 16 lines x 32 bytes.
// DCACHE_STATS_EN adds hit_count_o / miss_count_o counters.
module dcache_controller (
  input  logic clk_i,
  input  logic rst_i,
  dcache_controller_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    READMISS
  } state_e;

  state_e state_q, state_d;

  logic [15:0]  valid_q, dirty_q;
  logic [22:0]  tag_q  [16];
  logic [255:0] line_q [16];

  logic [3:0]  idx;
  logic [22:0] tag;
  logic [2:0]  wsel;
  logic        req, wr, hit, ack;
  logic        idle, wr_hit, fill;
  logic [1:0]  unused;

  assign idx    = bus.cpu_addr_i[8:5];
  assign tag    = bus.cpu_addr_i[31:9];
  assign wsel   = bus.cpu_addr_i[4:2];
  assign unused = bus.cpu_addr_i[1:0];
  assign req    = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign wr     = bus.cpu_MemWrite_i;
  assign hit    = valid_q[idx] & (tag_q[idx] == tag);
  assign ack    = bus.mem_ack_i;
  assign idle   = (state_q == IDLE);
  assign wr_hit = idle & req & hit & wr;
  assign fill   = (state_q == READMISS) & ack;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req & ~hit)
          state_d = (valid_q[idx] & dirty_q[idx])
                  ? WRITEBACK : READMISS;
      end
      WRITEBACK: if (ack) state_d = READMISS;
      READMISS:  if (ack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_stall_o  = ~idle | (req & ~hit);
    bus.cpu_data_o   = '0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (req & hit & ~wr)
          bus.cpu_data_o = line_q[idx][{wsel, 5'b0} +: 32];
      end
      WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tag_q[idx], idx, 5'b0};
        bus.mem_data_o   = line_q[idx];
      end
      READMISS: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {tag, idx, 5'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= bus.mem_data_i;
    end else if (wr_hit) begin
      line_q[idx][{wsel, 5'b0} +: 32] <= bus.cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (idle & req & hit)  hit_count_o  <= hit_count_o + 32'd1;
      if (idle & req & ~hit) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule
